// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC generator plus a DEPTH-entry circular
// buffer of {inst, pc} pairs feeding decode in program order.
// Optional feature macro: FETCHQ_BYPASS_EN. When it is defined, an empty
// queue presents the instruction being fetched straight to decode in the
// same cycle.
//
// Decode handshake: validD plays the role of "valid" and ~stall plays the
// role of "ready". The head entry transfers on every cycle where validD=1
// and stall=0, unless flush=1, which overrides both. While stalled, instD,
// PCD and PCPlus4D hold steady.
module fetch_queue #(
   parameter int                XLEN     = 32,
   parameter int                DEPTH    = 4,
   parameter logic [XLEN-1:0]   RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [XLEN-1:0]          imem_addr,
   input  logic [31:0]              imem_inst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic [31:0]              instD,
   output logic [XLEN-1:0]          PCD,
   output logic [XLEN-1:0]          PCPlus4D,
   output logic                     validD,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0]      inst_mem_q [DEPTH];
   logic [XLEN-1:0]  pc_mem_q   [DEPTH];

   logic             full_w, empty_w;
   logic             pop, push;
   logic             buf_push, buf_pop;

   assign full_w  = (count_q == CNT_W'(DEPTH));
   assign empty_w = (count_q == '0);

   // Head selection and handshake: show-ahead head from the buffer, optionally
   // bypassing the fetch port when the buffer is empty. Buffer push/pop are
   // split from the architectural push/pop so a bypassed instruction that
   // decode accepts never touches storage.
   always_comb begin
      validD   = ~empty_w;
      instD    = NOP;
      PCD      = '0;
      PCPlus4D = '0;
`ifdef FETCHQ_BYPASS_EN
      if (empty_w) begin
         validD   = 1'b1;
         instD    = imem_inst;
         PCD      = imem_addr;
         PCPlus4D = imem_addr + XLEN'(4);
      end else begin
         instD    = inst_mem_q[rd_ptr_q];
         PCD      = pc_mem_q[rd_ptr_q];
         PCPlus4D = pc_mem_q[rd_ptr_q] + XLEN'(4);
      end
`else
      if (!empty_w) begin
         instD    = inst_mem_q[rd_ptr_q];
         PCD      = pc_mem_q[rd_ptr_q];
         PCPlus4D = pc_mem_q[rd_ptr_q] + XLEN'(4);
      end
`endif
      pop  = validD & ~stall & ~flush;
      push = ~flush & (~full_w | pop);
`ifdef FETCHQ_BYPASS_EN
      // A bypassed instruction consumed this cycle never enters the buffer.
      buf_push = push & ~(empty_w & pop);
      buf_pop  = pop & ~empty_w;
`else
      buf_push = push;
      buf_pop  = pop;
`endif
   end

   // Next-state for fetch PC, pointers and occupancy; flush clears the queue
   // and redirects fetch, taking priority over stall and full.
   always_comb begin
      pc_d     = pc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         pc_d     = redirect_pc;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            pc_d = pc_q + XLEN'(4);
         end
         if (buf_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (buf_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({buf_push, buf_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers; reset wins over flush, stall and push.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         pc_q     <= pc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents need no reset because validD gates the outputs.
   always_ff @(posedge clk) begin
      if (!reset && buf_push) begin
         inst_mem_q[wr_ptr_q] <= imem_inst;
         pc_mem_q[wr_ptr_q]   <= imem_addr;
      end
   end

   assign imem_addr = pc_q;
   assign count     = count_q;
   assign full      = full_w;
   assign empty     = empty_w;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue in its default build
// (DEPTH=4, RESET_PC=0, FETCHQ_BYPASS_EN undefined). The instruction memory
// model returns 0xA000_0000 | address, so every expected instruction is
// derived from its PC by hand.
module tb_fetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic            clk;
   logic            reset;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_inst;
   logic            stall;
   logic            flush;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     instD;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCPlus4D;
   logic            validD;
   logic [2:0]      count;
   logic            full;
   logic            empty;

   int checks   = 0;
   int failures = 0;

   fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset       (reset),
      .imem_addr   (imem_addr),
      .imem_inst   (imem_inst),
      .stall       (stall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .instD       (instD),
      .PCD         (PCD),
      .PCPlus4D    (PCPlus4D),
      .validD      (validD),
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // combinational instruction memory model
   assign imem_inst = 32'hA000_0000 | imem_addr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // advance one rising edge; outputs are sampled 1ns after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      stall       = 1'b0;
      flush       = 1'b0;
      redirect_pc = '0;
      step();
      step();

      // reset state
      check("rst_count",  32'(count),  32'd0);
      check("rst_empty",  32'(empty),  32'd1);
      check("rst_full",   32'(full),   32'd0);
      check("rst_valid",  32'(validD), 32'd0);
      check("rst_instD",  instD,       32'h0000_0013);
      check("rst_addr",   imem_addr,   32'h0);
      check("rst_PCD",    PCD,         32'h0);

      // free run: imem_addr 4,8,..; PCD lags by one fetch; count stays 1.
      // Six cycles wrap both pointers past DEPTH.
      reset = 1'b0;
      stall = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         check("run_addr",  imem_addr, 32'(4 * (k + 1)));
         check("run_PCD",   PCD,       32'(4 * k));
         check("run_PC4",   PCPlus4D,  32'(4 * k + 4));
         check("run_inst",  instD,     32'hA000_0000 | 32'(4 * k));
         check("run_count", 32'(count), 32'd1);
      end

      // stall for 6 cycles: fills to DEPTH, fetch holds at 0x10, head stays 0x0
      do_reset();
      stall = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check("stl_PCD",   PCD,        32'h0);
         check("stl_count", 32'(count), (k < 4) ? 32'(k + 1) : 32'd4);
      end
      check("stl_full",  32'(full),  32'd1);
      check("stl_addr",  imem_addr,  32'h10);
      check("stl_inst",  instD,      32'hA000_0000);

      // full, one cycle of no stall: pop 0x0 and push 0x10 together
      stall = 1'b0;
      step();
      stall = 1'b1;
      check("fp_count", 32'(count), 32'd4);
      check("fp_full",  32'(full),  32'd1);
      check("fp_PCD",   PCD,        32'h4);
      check("fp_addr",  imem_addr,  32'h14);
      // drain under partial stall to confirm order through the wrapped slot
      stall = 1'b0;
      step();
      stall = 1'b1;
      check("ord_PCD0", PCD, 32'h8);
      stall = 1'b0;
      step();
      check("ord_PCD1", PCD, 32'hC);
      step();
      check("ord_PCD2", PCD, 32'h10);
      check("ord_inst2", instD, 32'hA000_0010);

      // count=3, then flush with stall asserted
      do_reset();
      stall = 1'b1;
      step();
      step();
      step();
      check("pre_fl_count", 32'(count), 32'd3);
      flush       = 1'b1;
      redirect_pc = 32'h100;
      step();
      flush = 1'b0;
      check("fl_count", 32'(count),  32'd0);
      check("fl_valid", 32'(validD), 32'd0);
      check("fl_instD", instD,       32'h0000_0013);
      check("fl_addr",  imem_addr,   32'h100);
      check("fl_PCD",   PCD,         32'h0);
      check("fl_PC4",   PCPlus4D,    32'h0);
      check("fl_empty", 32'(empty),  32'd1);
      // first fetch after the redirect
      stall = 1'b0;
      step();
      check("rd_PCD",  PCD,        32'h100);
      check("rd_PC4",  PCPlus4D,   32'h104);
      check("rd_inst", instD,      32'hA000_0100);
      check("rd_addr", imem_addr,  32'h104);

      // fill up, then reset while full and stalled
      stall = 1'b1;
      step();
      step();
      step();
      check("pre_rst_full", 32'(full), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("fr_count", 32'(count),  32'd0);
      check("fr_empty", 32'(empty),  32'd1);
      check("fr_full",  32'(full),   32'd0);
      check("fr_addr",  imem_addr,   32'h0);
      check("fr_valid", 32'(validD), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
